mem_refill_arbiter: RTL

//  Shares one word-wide main-memory port between I-cache and D-cache line misses.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/line_word_counter.sv | 30 +++
 rtl/mem_refill_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the refill arbiter: FSM states, line owner, word byte offset.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam int WORD_OFF = 2;

endpackage

// File: rtl/line_word_counter.sv
// Word index within a cache line: cleared at grant, advanced on each acked word.
module line_word_counter #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             is_last
);

  logic [IDX_W-1:0] idx_q, idx_d;

  // Line length is a power of two, so the natural wrap returns idx to 0 at phase change.
  always_comb begin
    idx_d = idx_q;
    if (clr)      idx_d = '0;
    else if (inc) idx_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx     = idx_q;
  assign is_last = &idx_q;

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one word-wide memory port between I-cache and D-cache misses:
// optional D-cache write-back of the victim line, then a line fill.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; arbitrate pending requests at the edge
// ST_WB   | writing D-cache victim line, one word per mem_ack
// ST_FILL | reading the miss line for the owner, one word per mem_ack
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_fill_valid,
  output logic [IDX_W-1:0]      ic_fill_idx,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_dirty,
  input  logic [ADDR_WIDTH-1:0] dc_wb_addr,
  input  logic [DATA_WIDTH-1:0] dc_wb_data,
  output logic [IDX_W-1:0]      dc_wb_idx,
  output logic                  dc_fill_valid,
  output logic [IDX_W-1:0]      dc_fill_idx,
  output logic                  dc_done,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((1 << (IDX_W + WORD_OFF)) - 1);

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic [ADDR_WIDTH-1:0] wb_base_q, wb_base_d;
  logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
  logic                  grant, pick_dc;
  logic [IDX_W-1:0]      idx;
  logic                  is_last;
  logic                  in_wb, in_fill, word_ack;

  assign in_wb    = (state_q == ST_WB);
  assign in_fill  = (state_q == ST_FILL);
  assign word_ack = mem_req & mem_ack;

  line_word_counter #(.IDX_W(IDX_W)) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant),
    .inc     (word_ack),
    .idx     (idx),
    .is_last (is_last)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wb_base_d   = wb_base_q;
    fill_base_d = fill_base_q;
    grant       = 1'b0;
    pick_dc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ic_req || dc_req) begin
          grant = 1'b1;
          // On a tie the side not served last wins.
          pick_dc = dc_req && (!ic_req || last_q == OWN_IC);
          if (pick_dc) begin
            owner_d     = OWN_DC;
            last_d      = OWN_DC;
            fill_base_d = dc_addr & LINE_MASK;
            wb_base_d   = dc_wb_addr & LINE_MASK;
            state_d     = dc_dirty ? ST_WB : ST_FILL;
          end else begin
            owner_d     = OWN_IC;
            last_d      = OWN_IC;
            fill_base_d = ic_addr & LINE_MASK;
            state_d     = ST_FILL;
          end
        end
      end
      ST_WB:   if (mem_ack && is_last) state_d = ST_FILL;
      ST_FILL: if (mem_ack && is_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IC;
      last_q      <= OWN_IC;
      wb_base_q   <= '0;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_req   = in_wb | in_fill;
  assign mem_we    = in_wb;
  assign mem_addr  = mem_req ? ((in_wb ? wb_base_q : fill_base_q) +
                                (ADDR_WIDTH'(idx) << WORD_OFF)) : '0;
  assign mem_wdata = dc_wb_data;
  assign fill_data = mem_rdata;
  assign dc_wb_idx = in_wb ? idx : '0;

  assign ic_fill_valid = in_fill && (owner_q == OWN_IC) && mem_ack;
  assign dc_fill_valid = in_fill && (owner_q == OWN_DC) && mem_ack;
  assign ic_fill_idx   = (in_fill && owner_q == OWN_IC) ? idx : '0;
  assign dc_fill_idx   = (in_fill && owner_q == OWN_DC) ? idx : '0;
  assign ic_done       = ic_fill_valid & is_last;
  assign dc_done       = dc_fill_valid & is_last;

endmodule
